// File: rtl/alu_sweep_sequencer.sv
// Autonomous ALU exerciser: latches one operand pair, sweeps the opcode space in
// ascending order (skipping masked codes) and streams {sel, result} beats out.
module alu_sweep_sequencer #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned SEL_W  = 4,
   parameter int unsigned SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      op_a,
   input  logic [WIDTH-1:0]      op_b,
   input  logic [2**SEL_W-1:0]   skip_mask,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   output logic [SEL_W-1:0]      alu_sel,
   input  logic [WIDTH-1:0]      alu_c,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [SEL_W-1:0]      res_sel,
   output logic [WIDTH-1:0]      res_data,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned NCODE = 2**SEL_W;
   localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {IDLE, DRIVE, OUT, DONE} state_t;

   state_t             state, state_n;
   logic [NCODE-1:0]   mask_q, mask_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [WIDTH-1:0]   alu_a_n, alu_b_n, res_data_n;
   logic [SEL_W-1:0]   alu_sel_n, res_sel_n;

   logic               first_found, next_found;
   logic [SEL_W-1:0]   first_code, next_code;

   // Priority searches over a full-width index so the last code never wraps sel.
   always_comb begin
      first_found = 1'b0;
      first_code  = '0;
      next_found  = 1'b0;
      next_code   = '0;
      for (int unsigned i = 0; i < NCODE; i++) begin
         if (!first_found && !skip_mask[i]) begin
            first_found = 1'b1;
            first_code  = SEL_W'(i);
         end
         if (!next_found && !mask_q[i] && (i > 32'(alu_sel))) begin
            next_found = 1'b1;
            next_code  = SEL_W'(i);
         end
      end
   end

   always_comb begin
      state_n    = state;
      mask_n     = mask_q;
      cnt_n      = cnt;
      alu_a_n    = alu_a;
      alu_b_n    = alu_b;
      alu_sel_n  = alu_sel;
      res_sel_n  = res_sel;
      res_data_n = res_data;
      case (state)
         IDLE: begin
            if (start) begin
               alu_a_n = op_a;
               alu_b_n = op_b;
               mask_n  = skip_mask;
               if (first_found) begin
                  alu_sel_n = first_code;
                  cnt_n     = '0;
                  state_n   = DRIVE;
               end else begin
                  state_n = DONE;
               end
            end
         end
         DRIVE: begin
            if (cnt == CNT_W'(SETTLE - 1)) begin
               res_data_n = alu_c;
               res_sel_n  = alu_sel;
               state_n    = OUT;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         OUT: begin
            if (res_ready) begin
               if (next_found) begin
                  alu_sel_n = next_code;
                  cnt_n     = '0;
                  state_n   = DRIVE;
               end else begin
                  state_n = DONE;
               end
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         mask_q   <= '0;
         cnt      <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_sel  <= '0;
         res_sel  <= '0;
         res_data <= '0;
      end else begin
         state    <= state_n;
         mask_q   <= mask_n;
         cnt      <= cnt_n;
         alu_a    <= alu_a_n;
         alu_b    <= alu_b_n;
         alu_sel  <= alu_sel_n;
         res_sel  <= res_sel_n;
         res_data <= res_data_n;
      end
   end

   assign res_valid = (state == OUT);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

endmodule
